// File: rtl/gpio_run_controller_pkg.sv
// Shared types and constants for the GPIO-driven core run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ARMED = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } run_state_e;

  localparam logic [1:0] ST_NONE    = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_FAIL    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  localparam int CTRL_LOAD = 1;
  localparam int CTRL_RUN  = 0;

endpackage

// File: rtl/gpio_run_controller_if.sv
// Core data-store observation port seen by the run controller.
interface gpio_run_controller_if #(
  parameter int XLEN = 32
);
  // st_valid is a one-cycle strobe per store; there is no ready, the
  // observer always accepts and never back-pressures the core.
  logic            st_valid;
  logic [XLEN-1:0] st_addr;
  logic [XLEN-1:0] st_data;

  modport master (output st_valid, output st_addr, output st_data);
  modport slave  (input  st_valid, input  st_addr, input  st_data);
endinterface

// File: rtl/gpio_run_controller_counter.sv
// Saturating run-cycle counter with clear, enable and terminal-count flag.
// Terminal-count compare exists only when GPIO_RUN_CTRL_TIMEOUT_EN is defined.
module run_cycle_counter #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 1100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [XLEN-1:0] cnt_o,
  output logic            tc_o
);

  logic [XLEN-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

`ifdef GPIO_RUN_CTRL_TIMEOUT_EN
  // Flag the last permitted run cycle so the stop lands after exactly
  // TIMEOUT_CYCLES cycles of core_en.
  localparam logic [XLEN-1:0] TC_VAL = XLEN'(TIMEOUT_CYCLES - 1);
  assign tc_o = (cnt_q == TC_VAL);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tc_o = 1'b0;
`endif

endmodule

// File: rtl/gpio_run_controller.sv
// Sequences core reset/enable from GPIO control words and detects pass/fail
// stores. Watchdog stop is built only with GPIO_RUN_CTRL_TIMEOUT_EN defined.
module gpio_run_controller
  import run_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1100,
  parameter int XLEN           = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XLEN-1:0]       GPIO0_R0_CH1,
  input  logic [XLEN-1:0]       GPIO0_R0_CH2,
  input  logic [XLEN-1:0]       GPIO0_R1_CH1,
  input  logic [XLEN-1:0]       GPIO0_R1_CH2,
  gpio_run_controller_if.slave  st,
  output logic                  core_rst_n,
  output logic                  core_en,
  output logic [XLEN-1:0]       pc_init,
  output logic [XLEN-1:0]       mem_offset,
  output logic [XLEN-1:0]       cycle_count,
  output logic [1:0]            status,
  output logic                  STOP_sim,
  output run_state_e            dbg_state_o
);

  logic [1:0]      ctrl_q;
  run_state_e      state_q, state_d;
  logic [1:0]      status_q, status_d;
  logic [XLEN-1:0] mem_offset_q, pc_init_q, succ_q;
  logic            cnt_clr, cnt_en, cnt_tc;
  logic            store_hit;
  logic            unused_ctrl_hi;

  assign unused_ctrl_hi = ^GPIO0_R0_CH1[XLEN-1:2];

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    store_hit = st.st_valid && (st.st_addr == mem_offset_q);
    // Load overrides every other decision, including a store in the same cycle.
    if (ctrl_q[CTRL_LOAD]) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_LOAD:  state_d = S_ARMED;
        S_ARMED: if (ctrl_q[CTRL_RUN]) state_d = S_RUN;
        S_RUN: begin
          if (store_hit) begin
            state_d  = S_DONE;
            status_d = (st.st_data == succ_q) ? ST_PASS : ST_FAIL;
          end else if (cnt_tc) begin
            state_d  = S_DONE;
            status_d = ST_TIMEOUT;
          end else if (!ctrl_q[CTRL_RUN]) begin
            state_d = S_ARMED;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
    if (state_q == S_LOAD) begin
      status_d = ST_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= 2'b00;
      state_q      <= S_IDLE;
      status_q     <= ST_NONE;
      mem_offset_q <= '0;
      pc_init_q    <= '0;
      succ_q       <= '0;
    end else begin
      ctrl_q   <= GPIO0_R0_CH1[1:0];
      state_q  <= state_d;
      status_q <= status_d;
      if (state_q == S_LOAD) begin
        mem_offset_q <= GPIO0_R0_CH2;
        pc_init_q    <= GPIO0_R1_CH1;
        succ_q       <= GPIO0_R1_CH2;
      end
    end
  end

  assign cnt_clr = (state_q == S_LOAD);
  assign cnt_en  = (state_q == S_RUN);

  run_cycle_counter #(
    .XLEN           (XLEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cycle_count),
    .tc_o  (cnt_tc)
  );

  assign core_rst_n  = (state_q != S_IDLE) && (state_q != S_LOAD);
  assign core_en     = (state_q == S_RUN);
  assign STOP_sim    = (state_q == S_DONE);
  assign status      = status_q;
  assign pc_init     = pc_init_q;
  assign mem_offset  = mem_offset_q;
  assign dbg_state_o = state_q;

endmodule
